// File: rtl/ahb_slave_if_param_if.sv
// AHB slave-side bundle between the interconnect and the bridge front-end.
// Carries the address/data phase inputs, pipeline taps and response.
interface ahb_slave_if_param_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SEL = 3
);
  logic              Hwrite;
  logic              Hreadyin;
  logic [1:0]        Htrans;
  logic [2:0]        Hsize;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              valid;
  logic [NUM_SEL-1:0] tempselx;
  logic [ADDR_W-1:0] Haddr1;
  logic [ADDR_W-1:0] Haddr2;
  logic [DATA_W-1:0] Hwdata1;
  logic [DATA_W-1:0] Hwdata2;
  logic              Hwritereg;
  logic [2:0]        Hsizereg;
  logic [DATA_W-1:0] Hrdata;
  logic              Hreadyout;
  logic [1:0]        Hresp;

  modport slave (
    input  Hwrite, Hreadyin, Htrans, Hsize,
    input  Haddr, Hwdata, Prdata, Pready,
    output valid, tempselx, Haddr1, Haddr2,
    output Hwdata1, Hwdata2, Hwritereg,
    output Hsizereg, Hrdata, Hreadyout, Hresp
  );

  modport master (
    output Hwrite, Hreadyin, Htrans, Hsize,
    output Haddr, Hwdata, Prdata, Pready,
    input  valid, tempselx, Haddr1, Haddr2,
    input  Hwdata1, Hwdata2, Hwritereg,
    input  Hsizereg, Hrdata, Hreadyout, Hresp
  );
endinterface

// File: rtl/ahb_slave_if_param.sv
// Parametrised AHB slave front-end: region decode, address/data pipeline
// toward the APB bridge FSM, and the two-cycle ERROR response.
module ahb_slave_if_param #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SEL     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int REGION_LOG2 = 26
) (
  input logic Hclk,
  input logic Hresetn,
  ahb_slave_if_param_if.slave bus
);

  localparam int AW1   = ADDR_W + 1;
  localparam int IW    = AW1 - REGION_LOG2;
  localparam int MAXSZ = $clog2(DATA_W / 8);
  localparam logic [ADDR_W:0] LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] SPAN = AW1'(NUM_SEL) << REGION_LOG2;
  localparam logic [ADDR_W:0] HI   = LO + SPAN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W:0] a_ext;
  logic [ADDR_W:0] off;
  logic [IW-1:0]   idx;
  logic            mapped;
  logic            legal;
  logic            active;

  // Widened compare: the top bound can't wrap, low addresses can't alias.
  assign a_ext  = {1'b0, bus.Haddr};
  assign mapped = (a_ext >= LO) && (a_ext < HI);
  assign off    = a_ext - LO;
  assign idx    = IW'(off >> REGION_LOG2);
  assign legal  = bus.Hsize <= 3'(MAXSZ);
  assign active = bus.Hreadyin && bus.Htrans[1];

  assign bus.valid = Hresetn && active && mapped &&
                     legal && (state != S_ERR1);
  assign bus.Hrdata = bus.Prdata;

  always_comb begin
    bus.tempselx = '0;
    for (int k = 0; k < NUM_SEL; k++)
      bus.tempselx[k] = Hresetn && mapped &&
                        (idx == IW'(k));
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      bus.Haddr1    <= '0;
      bus.Haddr2    <= '0;
      bus.Hwdata1   <= '0;
      bus.Hwdata2   <= '0;
      bus.Hwritereg <= 1'b0;
      bus.Hsizereg  <= 3'b000;
    end else if (bus.Hreadyin) begin
      bus.Haddr1    <= bus.Haddr;
      bus.Haddr2    <= bus.Haddr1;
      bus.Hwdata1   <= bus.Hwdata;
      bus.Hwdata2   <= bus.Hwdata1;
      bus.Hwritereg <= bus.Hwrite;
      bus.Hsizereg  <= bus.Hsize;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.Hreadyout = 1'b1;
    bus.Hresp     = 2'b00;
    unique case (state)
      S_IDLE: begin
        bus.Hreadyout = bus.Pready || !Hresetn;
        if (active && (!mapped || !legal))
          state_nx = S_ERR1;
      end
      S_ERR1: begin
        bus.Hreadyout = 1'b0;
        bus.Hresp     = 2'b01;
        state_nx      = S_ERR2;
      end
      S_ERR2: begin
        bus.Hresp = 2'b01;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// Directed bench for ahb_slave_if_param: default 3-region DUT plus a
// 4-region instance for the parameter sweep.
module tb_ahb_slave_if_param;

  logic Hclk = 1'b0;
  logic Hresetn;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  always #5 Hclk = ~Hclk;

  ahb_slave_if_param_if #(.NUM_SEL(3)) a ();
  ahb_slave_if_param_if #(.NUM_SEL(4)) b ();

  ahb_slave_if_param #(.NUM_SEL(3)) dut_a (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(a.slave)
  );
  ahb_slave_if_param #(.NUM_SEL(4)) dut_b (
    .Hclk(Hclk), .Hresetn(Hresetn), .bus(b.slave)
  );

  task automatic tick;
    @(posedge Hclk);
    #1;
  endtask

  task automatic idle_a(input logic [31:0] ad);
    a.Htrans = 2'b00; a.Haddr = ad;
    a.Hsize = 3'd2; a.Hwrite = 1'b0; a.Hreadyin = 1'b1;
  endtask

  task automatic test_reset;
    Hresetn = 1'b0;
    a.Hwrite = 1'b1; a.Hreadyin = 1'b1; a.Htrans = 2'b10;
    a.Hsize = 3'd2; a.Haddr = 32'h8000_0000;
    a.Hwdata = 32'hDEAD_BEEF; a.Prdata = 32'h1234_5678;
    a.Pready = 1'b1;
    b.Hwrite = 1'b0; b.Hreadyin = 1'b1; b.Htrans = 2'b00;
    b.Hsize = 3'd2; b.Haddr = 32'h0; b.Hwdata = 32'h0;
    b.Prdata = 32'h0; b.Pready = 1'b1;
    #12;
    tot_cnt++;
    if (a.valid !== 1'b0 || a.tempselx !== 3'b000)
      $display("FAIL reset_valid got %b/%b want 0/000",
               a.valid, a.tempselx);
    else pass_cnt++;
    tot_cnt++;
    if (a.Hreadyout !== 1'b1 || a.Hresp !== 2'b00)
      $display("FAIL reset_resp got %b/%b want 1/00",
               a.Hreadyout, a.Hresp);
    else pass_cnt++;
    tot_cnt++;
    if (a.Haddr1 !== 32'h0 || a.Hwdata1 !== 32'h0 ||
        a.Hwritereg !== 1'b0 || a.Hsizereg !== 3'd0)
      $display("FAIL reset_regs got %h %h %b %h want zeros",
               a.Haddr1, a.Hwdata1, a.Hwritereg, a.Hsizereg);
    else pass_cnt++;
    tot_cnt++;
    if (a.Hrdata !== 32'h1234_5678)
      $display("FAIL hrdata got %h want 12345678", a.Hrdata);
    else pass_cnt++;
    idle_a(32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick;
  endtask

  task automatic test_write;
    a.Haddr = 32'h8400_0010; a.Htrans = 2'b10;
    a.Hwrite = 1'b1; a.Hsize = 3'd2; a.Hreadyin = 1'b1;
    #1;
    tot_cnt++;
    if (a.valid !== 1'b1 || a.tempselx !== 3'b010)
      $display("FAIL wr_decode got %b/%b want 1/010",
               a.valid, a.tempselx);
    else pass_cnt++;
    tick;
    a.Htrans = 2'b00; a.Hwdata = 32'hA5A5_0001;
    tot_cnt++;
    if (a.Haddr1 !== 32'h8400_0010 || a.Hwritereg !== 1'b1)
      $display("FAIL wr_edge1 got %h/%b want 84000010/1",
               a.Haddr1, a.Hwritereg);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (a.Hwdata1 !== 32'hA5A5_0001 ||
        a.Haddr2 !== 32'h8400_0010 || a.Hresp !== 2'b00)
      $display("FAIL wr_edge2 got %h %h %b want a5a50001 84000010 00",
               a.Hwdata1, a.Haddr2, a.Hresp);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    idle_a(32'h8000_0100);
    a.Hwdata = 32'h11;
    tick;
    for (int i = 0; i < 3; i++) begin
      a.Hreadyin = 1'b0;
      a.Haddr = 32'h8000_0300 + 32'(i);
      a.Hwdata = 32'h99 + 32'(i);
      tick;
      tot_cnt++;
      if (a.Haddr1 !== 32'h8000_0100 ||
          a.Haddr2 !== 32'h8400_0010 || a.Hwdata1 !== 32'h11)
        $display("FAIL stall%0d got %h %h %h want 80000100 84000010 11",
                 i, a.Haddr1, a.Haddr2, a.Hwdata1);
      else pass_cnt++;
    end
    a.Hreadyin = 1'b1; a.Haddr = 32'h8000_0200; a.Hwdata = 32'h22;
    tick;
    tot_cnt++;
    if (a.Haddr1 !== 32'h8000_0200 ||
        a.Haddr2 !== 32'h8000_0100 || a.Hwdata1 !== 32'h22)
      $display("FAIL resume got %h %h %h want 80000200 80000100 22",
               a.Haddr1, a.Haddr2, a.Hwdata1);
    else pass_cnt++;
  endtask

  task automatic test_unmapped;
    logic [31:0] addrs [2];
    logic [1:0]  tr [2];
    addrs[0] = 32'h7FFF_FFFC; tr[0] = 2'b10;
    addrs[1] = 32'h8C00_0000; tr[1] = 2'b11;
    for (int i = 0; i < 2; i++) begin
      a.Haddr = addrs[i]; a.Htrans = tr[i]; a.Hsize = 3'd2;
      #1;
      tot_cnt++;
      if (a.valid !== 1'b0 || a.tempselx !== 3'b000 ||
          a.Hreadyout !== 1'b1 || a.Hresp !== 2'b00)
        $display("FAIL unm%0d_addr got %b %b %b %b want 0 000 1 00",
                 i, a.valid, a.tempselx, a.Hreadyout, a.Hresp);
      else pass_cnt++;
      tick;
      a.Htrans = 2'b00;
      #1;
      tot_cnt++;
      if (a.Hreadyout !== 1'b0 || a.Hresp !== 2'b01)
        $display("FAIL unm%0d_err1 got %b/%b want 0/01",
                 i, a.Hreadyout, a.Hresp);
      else pass_cnt++;
      tick;
      tot_cnt++;
      if (a.Hreadyout !== 1'b1 || a.Hresp !== 2'b01)
        $display("FAIL unm%0d_err2 got %b/%b want 1/01",
                 i, a.Hreadyout, a.Hresp);
      else pass_cnt++;
      // Unmapped request in ERR2 must not start a new error sequence.
      if (i == 1) begin
        a.Haddr = 32'h7000_0000; a.Htrans = 2'b10;
      end
      tick;
      a.Htrans = 2'b00;
      #1;
      tot_cnt++;
      if (a.Hreadyout !== 1'b1 || a.Hresp !== 2'b00)
        $display("FAIL unm%0d_done got %b/%b want 1/00",
                 i, a.Hreadyout, a.Hresp);
      else pass_cnt++;
    end
  endtask

  task automatic test_size;
    a.Haddr = 32'h8000_0000; a.Htrans = 2'b10; a.Hsize = 3'b011;
    #1;
    tot_cnt++;
    if (a.valid !== 1'b0 || a.tempselx !== 3'b001)
      $display("FAIL size_bad got %b/%b want 0/001",
               a.valid, a.tempselx);
    else pass_cnt++;
    tick;
    // ERR2 accepts a fresh legal transfer.
    a.Htrans = 2'b00;
    #1;
    tot_cnt++;
    if (a.Hreadyout !== 1'b0 || a.Hresp !== 2'b01)
      $display("FAIL size_err1 got %b/%b want 0/01",
               a.Hreadyout, a.Hresp);
    else pass_cnt++;
    tick;
    a.Htrans = 2'b10; a.Hsize = 3'b010;
    #1;
    tot_cnt++;
    if (a.valid !== 1'b1 || a.Hresp !== 2'b01)
      $display("FAIL size_err2_valid got %b/%b want 1/01",
               a.valid, a.Hresp);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (a.valid !== 1'b1 || a.tempselx !== 3'b001 ||
        a.Hresp !== 2'b00)
      $display("FAIL size_ok got %b %b %b want 1 001 00",
               a.valid, a.tempselx, a.Hresp);
    else pass_cnt++;
    a.Htrans = 2'b00;
    tick;
  endtask

  task automatic test_reset_mid;
    a.Haddr = 32'h0000_1000; a.Htrans = 2'b10;
    tick;
    a.Htrans = 2'b00;
    #2;
    Hresetn = 1'b0;
    #1;
    tot_cnt++;
    if (a.Hresp !== 2'b00 || a.Hreadyout !== 1'b1 ||
        a.Haddr1 !== 32'h0)
      $display("FAIL reset_mid got %b %b %h want 00 1 0",
               a.Hresp, a.Hreadyout, a.Haddr1);
    else pass_cnt++;
    @(negedge Hclk);
    Hresetn = 1'b1;
    tick;
    tot_cnt++;
    if (a.Hresp !== 2'b00)
      $display("FAIL reset_mid_after got %b want 00", a.Hresp);
    else pass_cnt++;
  endtask

  task automatic test_sweep;
    b.Haddr = 32'h8C00_0004; b.Htrans = 2'b10; b.Hsize = 3'd2;
    #1;
    tot_cnt++;
    if (b.valid !== 1'b1 || b.tempselx !== 4'b1000)
      $display("FAIL sw_reg3 got %b/%b want 1/1000",
               b.valid, b.tempselx);
    else pass_cnt++;
    tick;
    b.Haddr = 32'h9000_0000;
    #1;
    tot_cnt++;
    if (b.valid !== 1'b0 || b.tempselx !== 4'b0000)
      $display("FAIL sw_top got %b/%b want 0/0000",
               b.valid, b.tempselx);
    else pass_cnt++;
    tick;
    b.Htrans = 2'b00;
    #1;
    tot_cnt++;
    if (b.Hreadyout !== 1'b0 || b.Hresp !== 2'b01)
      $display("FAIL sw_err1 got %b/%b want 0/01",
               b.Hreadyout, b.Hresp);
    else pass_cnt++;
    tick;
    tick;
    b.Haddr = 32'h8400_0000; b.Htrans = 2'b01;
    #1;
    tot_cnt++;
    if (b.valid !== 1'b0)
      $display("FAIL sw_busy got %b want 0", b.valid);
    else pass_cnt++;
    tick;
    tot_cnt++;
    if (b.Hreadyout !== 1'b1 || b.Hresp !== 2'b00)
      $display("FAIL sw_busy_resp got %b/%b want 1/00",
               b.Hreadyout, b.Hresp);
    else pass_cnt++;
    b.Htrans = 2'b00; b.Pready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tot_cnt++;
      if (b.Hreadyout !== 1'b0)
        $display("FAIL sw_wait%0d got %b want 0", i, b.Hreadyout);
      else pass_cnt++;
      tick;
    end
    b.Pready = 1'b1;
    #1;
    tot_cnt++;
    if (b.Hreadyout !== 1'b1)
      $display("FAIL sw_wait_end got %b want 1", b.Hreadyout);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_write;
    test_stall;
    test_unmapped;
    test_size;
    test_reset_mid;
    test_sweep;
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/ahb_slave_if_param.md
# ahb_slave_if_param

Parametrised AHB slave front-end for the AHB-to-APB bridge. It replaces the fixed three-region, 32-bit slave interface. It decodes a configurable number of equal-size peripheral regions and pipelines address, data, write and size toward the bridge FSM, holding them when the bus stalls. It also generates the AMBA two-cycle ERROR response for unmapped addresses and unsupported transfer sizes. It sits between the AHB master/interconnect and the bridge FSM (APB controller).

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64)
- NUM_SEL, 3, number of decoded regions / select lines (1..8)
- BASE_ADDR, 32'h8000_0000, start of region 0 (ADDR_W bits)
- REGION_LOG2, 26, log2 of each region's size (64 MB default)

Ports:
- Hclk  in  1  bus clock, all state on rising edge
- Hresetn  in  1  asynchronous, active-low reset
- Hwrite  in  1  transfer direction, 1 = write
- Hreadyin  in  1  bus-level HREADY
- Htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- Hsize  in  3  transfer size code
- Haddr  in  ADDR_W  address-phase address
- Hwdata  in  DATA_W  write data
- Prdata  in  DATA_W  read data from bridge FSM
- Pready  in  1  bridge FSM ready; 0 inserts wait states
- valid  out  1  combinational: accepted, mapped, legal transfer this cycle
- tempselx  out  NUM_SEL  combinational one-hot region select
- Haddr1, Haddr2  out  ADDR_W  address pipeline stages 1, 2
- Hwdata1, Hwdata2  out  DATA_W  write-data pipeline stages 1, 2
- Hwritereg  out  1  registered Hwrite
- Hsizereg  out  3  registered Hsize
- Hrdata  out  DATA_W  equals Prdata
- Hreadyout  out  1  slave HREADYOUT
- Hresp  out  2  00 = OKAY, 01 = ERROR

## Operation
- **Region decode:**
  - Region k covers [BASE_ADDR + k·2^REGION_LOG2, BASE_ADDR + (k+1)·2^REGION_LOG2).
  - An address is mapped iff BASE_ADDR ≤ Haddr < BASE_ADDR + NUM_SEL·2^REGION_LOG2.
  - Compare in ADDR_W+1 bits so the upper bound never wraps.
  - Haddr below BASE_ADDR is unmapped and must never alias via subtraction wrap.
  - tempselx has bit k set for a mapped address; it is 0 otherwise.
- **Size check:** legal iff Hsize ≤ log2(DATA_W/8).
- **Active transfer:** Hreadyin=1 and Htrans ∈ {NONSEQ, SEQ}.
- **valid** = active & mapped & legal size & state≠ERR1.
- **Error trigger:** active & (unmapped | illegal size) in state IDLE.
- **Pipeline registers:** update only on an edge where Hreadyin=1:
  - Haddr1←Haddr and Haddr2←Haddr1
  - Hwdata1←Hwdata and Hwdata2←Hwdata1
  - Hwritereg←Hwrite and Hsizereg←Hsize
  - When Hreadyin=0, all hold their values.
- **Response state machine:** states IDLE, ERR1, ERR2.
  - IDLE: Hreadyout=Pready, Hresp=00. Goes to ERR1 on the error trigger.
  - ERR1: Hreadyout=0, Hresp=01. Unconditionally goes to ERR2.
  - ERR2: Hreadyout=1, Hresp=01. Unconditionally goes to IDLE. An active transfer presented in ERR2 is decoded normally (valid may be 1) but cannot start a new error sequence until IDLE.
- BUSY and IDLE transfers never assert valid and never trigger an error.

## Timing
- **Reset:** while Hresetn=0, asynchronously:
  - Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg and Hsizereg = 0
  - state = IDLE
  - valid=0, tempselx=0, Hreadyout=1, Hresp=00
- **Reset mid-operation:** Hresetn dropping during ERR1/ERR2 aborts the sequence immediately. Hresp=00 is required within the same cycle.
- **Latency:**
  - valid and tempselx: zero cycles (combinational from Haddr/Htrans/Hreadyin/Hsize).
  - Haddr1: 1 edge after the accepted address phase. Haddr2: 2 accepted edges.
  - Hwdata1 captures data-phase Hwdata 1 edge after the data phase (2 edges after the address phase).
- **Error response:** address phase at edge n → ERR1 during cycle n..n+1 → ERR2 during n+1..n+2 → IDLE.
- **Pready:** Pready=0 in IDLE holds Hreadyout=0 for exactly as many cycles as Pready is low. No registering.
- Hrdata is combinationally equal to Prdata with zero latency.

## Test plan
- **Async reset:** run a transfer, pull Hresetn low mid-cycle → all registered outputs 0, Hreadyout=1, Hresp=00 before the next edge.
- **Mapped NONSEQ write:** Haddr=0x8400_0010, Hsize=010, Hreadyin=1, Hwdata=0xA5A5_0001 in the data phase →
  - valid=1 and tempselx=3'b010 in the address cycle
  - Haddr1=0x8400_0010 and Hwritereg=1 after edge 1
  - Hwdata1=0xA5A5_0001 after edge 2
  - Hresp=00 throughout
- **Stall:** Hreadyin=0 for 3 cycles while Haddr changes → Haddr1/Haddr2/Hwdata1 unchanged; they resume on the first edge with Hreadyin=1.
- **Unmapped address:** Haddr=0x7FFF_FFFC NONSEQ, then 0x8C00_0000 SEQ (after the first error completes) →
  - valid=0, tempselx=0
  - each produces Hreadyout 0 then 1 with Hresp=01 for two cycles, then OKAY
- **Illegal size (DATA_W=32):** Hsize=011 at 0x8000_0000 → valid=0, ERROR sequence. Hsize=010 at the same address → valid=1, tempselx=001.
- **Parameter sweep (NUM_SEL=4):** 0x8C00_0004 → tempselx=4'b1000, valid=1. 0x9000_0000 → error. BUSY at a mapped address → valid=0, no error. Pready=0 for 2 cycles → Hreadyout=0 for those 2 cycles.
